// File: rtl/exec_regfile_if.sv
// Decoder <-> execute-stage bus: one committed instruction per wr_en rising edge.
// Latency: not applicable (signal bundle only).
// Backpressure: none on the bus; busy/done report progress back to the decoder.
//
// Signals (decoder drives the first group, execute stage drives the second):
//   wr_en, rd_en, rs_en, imm_en, opcode[3:0], rd_addr[3:0], rs_addr[3:0], IMM
//   disp_data, result, flag_z, flag_c, busy, done
interface exec_regfile_if #(
  parameter int DATA_W = 8
);
  logic              wr_en;
  logic              rd_en;
  logic              rs_en;
  logic              imm_en;
  logic [3:0]        opcode;
  logic [3:0]        rd_addr;
  logic [3:0]        rs_addr;
  logic [DATA_W-1:0] IMM;

  logic [DATA_W-1:0] disp_data;
  logic [DATA_W-1:0] result;
  logic              flag_z;
  logic              flag_c;
  logic              busy;
  logic              done;

  // Decoder side
  modport master (
    output wr_en, rd_en, rs_en, imm_en, opcode, rd_addr, rs_addr, IMM,
    input  disp_data, result, flag_z, flag_c, busy, done
  );

  // Execute-stage side
  modport slave (
    input  wr_en, rd_en, rs_en, imm_en, opcode, rd_addr, rs_addr, IMM,
    output disp_data, result, flag_z, flag_c, busy, done
  );
endinterface

// File: rtl/exec_regfile.sv
// Execute stage: 16 x 8-bit register file plus 8-bit ALU, one commit per wr_en rising edge.
// Latency: start seen at edge 0, register/result/flags written at edge 2, done high after edge 2.
// Backpressure: rising edges of wr_en outside IDLE are dropped; HOLD waits for wr_en release.
//
// Ports: clk (rising-edge), rst (async active-high),
//        bus (exec_regfile_if.slave) carrying decoder inputs and display/status outputs.
module exec_regfile #(
  parameter int DATA_W = 8,
  parameter int NREGS  = 16
) (
  input  logic          clk,
  input  logic          rst,
  exec_regfile_if.slave bus
);

  localparam int AW = 4;

  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_LD  = 4'b0001;
  localparam logic [3:0] OP_MOV = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0100;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_OR  = 4'b0110;
  localparam logic [3:0] OP_XOR = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b1000;
  localparam logic [3:0] OP_SHL = 4'b1001;
  localparam logic [3:0] OP_SHR = 4'b1010;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WB   = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic              wr_en_q;
  logic              start;
  logic              capture;

  // Instruction latched at capture; later bus changes cannot affect it.
  logic [3:0]        op_q;
  logic [AW-1:0]     rd_q;
  logic [DATA_W-1:0] imm_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;

  // Bit DATA_W of the ALU output is the carry/borrow.
  logic [DATA_W:0]   alu_d;
  logic [DATA_W:0]   alu_q;

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] disp_q;
  logic [DATA_W-1:0] result_q;
  logic              flag_z_q;
  logic              flag_c_q;
  logic              done_q;

  logic              op_writes;
  logic              op_flags;

  // ------------------------------------------------------------------
  // Start detection: only the first cycle of a button press counts.
  // ------------------------------------------------------------------
  assign start   = bus.wr_en & ~wr_en_q;
  assign capture = (state_q == S_IDLE) && start;

  // ------------------------------------------------------------------
  // FSM
  // ------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_EXEC;
      S_EXEC: state_d = S_WB;
      S_WB:   state_d = S_HOLD;
      S_HOLD: if (!bus.wr_en) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ------------------------------------------------------------------
  // Opcode classification (undefined opcodes neither write nor touch flags)
  // ------------------------------------------------------------------
  always_comb begin
    op_writes = 1'b0;
    op_flags  = 1'b0;
    case (op_q)
      OP_LD, OP_MOV: op_writes = 1'b1;
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_SHL, OP_SHR: begin
        op_writes = 1'b1;
        op_flags  = 1'b1;
      end
      default: begin
        op_writes = 1'b0;
        op_flags  = 1'b0;
      end
    endcase
  end

  // ------------------------------------------------------------------
  // ALU on latched operands
  // ------------------------------------------------------------------
  always_comb begin
    alu_d = '0;
    case (op_q)
      OP_NOP: alu_d = '0;
      OP_LD:  alu_d = {1'b0, imm_q};
      OP_MOV: alu_d = {1'b0, b_q};
      OP_ADD: alu_d = {1'b0, a_q} + {1'b0, b_q};
      // Top bit of the 9-bit difference is set exactly when A < B.
      OP_SUB: alu_d = {1'b0, a_q} - {1'b0, b_q};
      OP_AND: alu_d = {1'b0, a_q & b_q};
      OP_OR:  alu_d = {1'b0, a_q | b_q};
      OP_XOR: alu_d = {1'b0, a_q ^ b_q};
      OP_NOT: alu_d = {1'b0, ~b_q};
      OP_SHL: alu_d = {a_q, 1'b0};
      // Shifted-out LSB lands in the carry position.
      OP_SHR: alu_d = {a_q[0], 1'b0, a_q[DATA_W-1:1]};
      default: alu_d = '0;
    endcase
  end

  // ------------------------------------------------------------------
  // Datapath state
  // ------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en_q  <= 1'b0;
      op_q     <= '0;
      rd_q     <= '0;
      imm_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      alu_q    <= '0;
      disp_q   <= '0;
      result_q <= '0;
      flag_z_q <= 1'b0;
      flag_c_q <= 1'b0;
      done_q   <= 1'b0;
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      wr_en_q <= bus.wr_en;
      done_q  <= (state_q == S_WB);

      // Display follows the live bus every cycle, in every state.
      if (bus.imm_en) begin
        disp_q <= bus.IMM;
      end else if (bus.rs_en) begin
        disp_q <= regs_q[bus.rs_addr];
      end else begin
        disp_q <= '0;
      end

      // Operands are read here, before any write-back, so rd == rs aliases cleanly.
      if (capture) begin
        op_q  <= bus.opcode;
        rd_q  <= bus.rd_addr;
        imm_q <= bus.IMM;
        a_q   <= bus.rd_en ? regs_q[bus.rd_addr] : '0;
        b_q   <= bus.rs_en ? regs_q[bus.rs_addr] : '0;
      end

      if (state_q == S_EXEC) begin
        alu_q <= alu_d;
      end

      // Sole register write path.
      if (state_q == S_WB) begin
        if (op_writes) begin
          regs_q[rd_q] <= alu_q[DATA_W-1:0];
          result_q     <= alu_q[DATA_W-1:0];
        end
        if (op_flags) begin
          flag_z_q <= (alu_q[DATA_W-1:0] == '0);
          flag_c_q <= alu_q[DATA_W];
        end
      end
    end
  end

  // ------------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------------
  assign bus.disp_data = disp_q;
  assign bus.result    = result_q;
  assign bus.flag_z    = flag_z_q;
  assign bus.flag_c    = flag_c_q;
  assign bus.busy      = (state_q == S_EXEC) || (state_q == S_WB);
  assign bus.done      = done_q;

endmodule

// File: tb/tb_exec_regfile.sv
// Testbench for exec_regfile: directed steps, scoreboard of result/flags popped on done.
// Latency: expects done on the third edge after the wr_en rise.
// Backpressure: exercises held button, dropped edges and reset abort.
module tb_exec_regfile;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  exec_regfile_if bus ();

  exec_regfile dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [7:0] res;
    logic       z;
    logic       c;
  } exp_t;

  exp_t       sb [$];
  logic [7:0] mregs [16];
  logic [7:0] mres;
  logic       mz;
  logic       mc;

  int checks   = 0;
  int errors   = 0;
  int done_cnt = 0;
  int d0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every done pulse must match the oldest expected commit.
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      done_cnt++;
      if (sb.size() == 0) begin
        chk("sb_unexpected_done", sb.size(), 1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_result", bus.result, e.res);
        chk("sb_flag_z", bus.flag_z, e.z);
        chk("sb_flag_c", bus.flag_c, e.c);
      end
    end
  end

  // Put an instruction on the bus and push the model's expected result/flags.
  task automatic drive(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rs,
                       input logic [7:0] imm, input logic ren, input logic sen, input logic ien);
    int   a, b, r;
    logic c, wr, fl;
    exp_t e;
    bus.opcode  = op;
    bus.rd_addr = rd;
    bus.rs_addr = rs;
    bus.IMM     = imm;
    bus.rd_en   = ren;
    bus.rs_en   = sen;
    bus.imm_en  = ien;
    a  = ren ? int'(mregs[rd]) : 0;
    b  = sen ? int'(mregs[rs]) : 0;
    r  = 0;
    c  = 1'b0;
    wr = 1'b1;
    fl = 1'b1;
    case (op)
      4'd1: begin r = int'(imm); fl = 1'b0; end
      4'd2: begin r = b; fl = 1'b0; end
      4'd3: begin r = (a + b) % 256; c = (a + b) > 255; end
      4'd4: begin r = (a - b + 256) % 256; c = (a < b); end
      4'd5: r = a & b;
      4'd6: r = a | b;
      4'd7: r = a ^ b;
      4'd8: r = 255 - b;
      4'd9: begin r = (a * 2) % 256; c = (a >= 128); end
      4'd10: begin r = a / 2; c = (a % 2) == 1; end
      default: begin wr = 1'b0; fl = 1'b0; end
    endcase
    if (wr) begin
      mregs[rd] = r[7:0];
      mres      = r[7:0];
    end
    if (fl) begin
      mz = (r == 0);
      mc = c;
    end
    e.res = mres;
    e.z   = mz;
    e.c   = mc;
    sb.push_back(e);
  endtask

  // Wait (bounded) for done; n0 negedges already elapsed since wr_en rose.
  task automatic wait_done(input string tag, input int n0);
    int n;
    bit got;
    n   = n0;
    got = 1'b0;
    while (!got && n < 10) begin
      @(negedge clk);
      n++;
      if (bus.done === 1'b1) got = 1'b1;
    end
    chk({tag, "_latency"}, n, 3);
  endtask

  task automatic release_btn();
    @(negedge clk);
    bus.wr_en = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic commit(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rs,
                        input logic [7:0] imm, input logic ren, input logic sen,
                        input logic ien, input int hold);
    @(negedge clk);
    drive(op, rd, rs, imm, ren, sen, ien);
    bus.wr_en = 1'b1;
    wait_done("commit", 0);
    repeat (hold) @(negedge clk);
    release_btn();
  endtask

  task automatic rd_reg(input string tag, input logic [3:0] addr, input logic [7:0] exp);
    @(negedge clk);
    bus.imm_en  = 1'b0;
    bus.rs_en   = 1'b1;
    bus.rs_addr = addr;
    repeat (2) @(negedge clk);
    chk(tag, bus.disp_data, exp);
  endtask

  task automatic model_reset();
    sb.delete();
    for (int i = 0; i < 16; i++) mregs[i] = 8'h00;
    mres = 8'h00;
    mz   = 1'b0;
    mc   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.wr_en   = 1'b0;
    bus.rd_en   = 1'b0;
    bus.rs_en   = 1'b0;
    bus.imm_en  = 1'b0;
    bus.opcode  = 4'h0;
    bus.rd_addr = 4'h0;
    bus.rs_addr = 4'h0;
    bus.IMM     = 8'h00;
    model_reset();
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_disp",   bus.disp_data, 8'h00);
    chk("rst_result", bus.result,    8'h00);
    chk("rst_z",      bus.flag_z,    1'b0);
    chk("rst_c",      bus.flag_c,    1'b0);
    chk("rst_busy",   bus.busy,      1'b0);
    chk("rst_done",   bus.done,      1'b0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // LD R2 = A5, with opcode/rd scrambled after capture
    @(negedge clk);
    drive(4'h1, 4'd2, 4'd0, 8'hA5, 1'b0, 1'b0, 1'b1);
    bus.wr_en = 1'b1;
    @(negedge clk);
    chk("ld_busy", bus.busy, 1'b1);
    bus.opcode  = 4'h7;
    bus.rd_addr = 4'd9;
    wait_done("ld", 1);
    chk("ld_disp", bus.disp_data, 8'hA5);
    chk("ld_flag_z", bus.flag_z, 1'b0);
    chk("ld_flag_c", bus.flag_c, 1'b0);
    release_btn();
    chk("ld_busy_idle", bus.busy, 1'b0);
    rd_reg("ld_R2", 4'd2, 8'hA5);
    rd_reg("ld_R9_untouched", 4'd9, 8'h00);

    // ADD with carry, then SUB R1,R1
    commit(4'h1, 4'd1, 4'd0, 8'hF0, 1'b0, 1'b0, 1'b1, 0);
    commit(4'h1, 4'd2, 4'd0, 8'h20, 1'b0, 1'b0, 1'b1, 0);
    commit(4'h3, 4'd1, 4'd2, 8'h00, 1'b1, 1'b1, 1'b0, 0);
    rd_reg("add_R1", 4'd1, 8'h10);
    chk("add_c", bus.flag_c, 1'b1);
    chk("add_z", bus.flag_z, 1'b0);
    commit(4'h4, 4'd1, 4'd1, 8'h00, 1'b1, 1'b1, 1'b0, 0);
    rd_reg("sub_R1", 4'd1, 8'h00);
    chk("sub_z", bus.flag_z, 1'b1);
    chk("sub_c", bus.flag_c, 1'b0);

    // Held button: one commit only
    commit(4'h1, 4'd1, 4'd0, 8'h01, 1'b0, 1'b0, 1'b1, 0);
    commit(4'h1, 4'd2, 4'd0, 8'h01, 1'b0, 1'b0, 1'b1, 0);
    d0 = done_cnt;
    commit(4'h3, 4'd1, 4'd2, 8'h00, 1'b1, 1'b1, 1'b0, 18);
    chk("held_done_count", done_cnt - d0, 1);
    rd_reg("held_R1", 4'd1, 8'h02);
    commit(4'h3, 4'd1, 4'd2, 8'h00, 1'b1, 1'b1, 1'b0, 0);
    rd_reg("repress_R1", 4'd1, 8'h03);

    // Dropped edge: low in EXEC, high again in WB
    d0 = done_cnt;
    @(negedge clk);
    drive(4'h3, 4'd1, 4'd2, 8'h00, 1'b1, 1'b1, 1'b0);
    bus.wr_en = 1'b1;
    @(negedge clk);
    bus.wr_en = 1'b0;
    @(negedge clk);
    bus.wr_en = 1'b1;
    wait_done("drop", 2);
    repeat (4) @(negedge clk);
    release_btn();
    chk("drop_done_count", done_cnt - d0, 1);
    rd_reg("drop_R1", 4'd1, 8'h04);

    // Reset during EXEC aborts
    d0 = done_cnt;
    @(negedge clk);
    drive(4'h3, 4'd1, 4'd2, 8'h00, 1'b1, 1'b1, 1'b0);
    bus.wr_en = 1'b1;
    @(negedge clk);
    chk("abort_busy", bus.busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("abort_disp",   bus.disp_data, 8'h00);
    chk("abort_result", bus.result,    8'h00);
    chk("abort_z",      bus.flag_z,    1'b0);
    chk("abort_busy0",  bus.busy,      1'b0);
    model_reset();
    bus.wr_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("abort_no_done", done_cnt - d0, 0);
    rd_reg("abort_R1", 4'd1, 8'h00);
    rd_reg("abort_R2", 4'd2, 8'h00);

    // Shifts and undefined opcode
    commit(4'h1, 4'd4, 4'd0, 8'h81, 1'b0, 1'b0, 1'b1, 0);
    commit(4'h9, 4'd4, 4'd0, 8'h00, 1'b1, 1'b0, 1'b0, 0);
    rd_reg("shl_R4", 4'd4, 8'h02);
    chk("shl_c", bus.flag_c, 1'b1);
    chk("shl_z", bus.flag_z, 1'b0);
    d0 = done_cnt;
    commit(4'hF, 4'd4, 4'd4, 8'h55, 1'b1, 1'b1, 1'b0, 0);
    chk("undef_done", done_cnt - d0, 1);
    rd_reg("undef_R4", 4'd4, 8'h02);
    chk("undef_c", bus.flag_c, 1'b1);
    commit(4'hA, 4'd4, 4'd0, 8'h00, 1'b1, 1'b0, 1'b0, 0);
    rd_reg("shr_R4", 4'd4, 8'h01);
    chk("shr_c", bus.flag_c, 1'b0);

    // Logic ops, NOT, MOV, NOP (scoreboard checks result/flags)
    commit(4'h1, 4'd5, 4'd0, 8'h3C, 1'b0, 1'b0, 1'b1, 0);
    commit(4'h1, 4'd6, 4'd0, 8'h0F, 1'b0, 1'b0, 1'b1, 0);
    commit(4'h5, 4'd5, 4'd6, 8'h00, 1'b1, 1'b1, 1'b0, 0);
    rd_reg("and_R5", 4'd5, 8'h0C);
    commit(4'h6, 4'd5, 4'd6, 8'h00, 1'b1, 1'b1, 1'b0, 0);
    rd_reg("or_R5", 4'd5, 8'h0F);
    commit(4'h7, 4'd5, 4'd6, 8'h00, 1'b1, 1'b1, 1'b0, 0);
    rd_reg("xor_R5", 4'd5, 8'h00);
    chk("xor_z", bus.flag_z, 1'b1);
    commit(4'h8, 4'd7, 4'd6, 8'h00, 1'b0, 1'b1, 1'b0, 0);
    rd_reg("not_R7", 4'd7, 8'hF0);
    commit(4'h2, 4'd8, 4'd7, 8'h00, 1'b0, 1'b1, 1'b0, 0);
    rd_reg("mov_R8", 4'd8, 8'hF0);
    commit(4'h0, 4'd8, 4'd6, 8'h00, 1'b1, 1'b1, 1'b0, 0);
    rd_reg("nop_R8", 4'd8, 8'hF0);

    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
